// File: rtl/serial_adder_if.sv
// Handshake/bus bundle for serial_adder: request side (start, operands,
// carry-in) and response side (ready, done, sum, carry-out, overflow).
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  ready, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output ready, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder computing a + b + cin over WIDTH bits,
// BPC bits per clock through a single BPC-bit adder slice.
// Handshake: start is accepted in IDLE (ready=1); done pulses for one cycle
// N = WIDTH/BPC edges after the accepting edge; sum/cout/ovf hold until the
// next completion.
// Optional feature macro: SERIAL_ADDER_OVF_EN -- when defined, ovf reports
// two's-complement overflow of the last completed add; otherwise ovf is 0.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

    generate
        if ((WIDTH < 1) || (BPC < 1) || ((WIDTH % BPC) != 0)) begin : g_bad_cfg
            $error("serial_adder: BPC must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [BPC:0]     slice_s;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] psum_d;
    logic             carry_d;
    logic [CW-1:0]    cnt_d;

    // One BPC-bit slice step: add low operand bits plus carry, shift the result into the partial sum from the top.
    always_comb begin
        slice_s = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
        a_d     = a_q >> BPC;
        b_d     = b_q >> BPC;
        psum_d  = psum_q >> BPC;
        psum_d[WIDTH-1 -: BPC] = slice_s[BPC-1:0];
        carry_d = slice_s[BPC];
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    logic carry_top_s;
    logic ovf_d;

    // Overflow of the final slice: carry into its top bit (a^b^s) against carry out of it.
    always_comb begin
        carry_top_s = a_q[BPC-1] ^ b_q[BPC-1] ^ slice_s[BPC-1];
        ovf_d       = carry_top_s ^ slice_s[BPC];
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            psum_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        psum_q  <= {WIDTH{1'b0}};
                        cnt_q   <= {CW{1'b0}};
                        ready_q <= 1'b0;
                        state_q <= S_RUN;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    psum_q  <= psum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    ready_q <= 1'b0;
                    if (cnt_q == CW'(N - 1)) begin
                        sum_q   <= psum_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (BPC=1, 4, 8 at
// WIDTH=8) driven with directed vectors; expected results are queued at
// issue time and checked by a negedge monitor whenever done is seen.
module tb_serial_adder;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OE = 1'b1;
`else
    localparam bit OE = 1'b0;
`endif

    typedef struct {
        logic [7:0]  sum;
        logic        cout;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned cyc;
    int n_cmp;
    int n_fail;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    serial_adder_if #(.WIDTH(8)) if8  ();
    serial_adder_if #(.WIDTH(8)) if4  ();
    serial_adder_if #(.WIDTH(8)) if88 ();

    serial_adder #(.WIDTH(8), .BPC(1)) u_bpc1 (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(8), .BPC(4)) u_bpc4 (.clk(clk), .rst(rst), .bus(if4));
    serial_adder #(.WIDTH(8), .BPC(8)) u_bpc8 (.clk(clk), .rst(rst), .bus(if88));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int sel, input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        bit have;
        have = 1'b0;
        case (sel)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_cmp++;
        if (!have) begin
            n_fail++;
            $display("FAIL unexpected_done inst%0d: got done with sum=%h, required no done", sel, s);
        end else if (s !== e.sum || c !== e.cout || o !== e.ovf || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL result inst%0d: got sum=%h cout=%b ovf=%b cyc=%0d, required sum=%h cout=%b ovf=%b cyc=%0d",
                     sel, s, c, o, cyc, e.sum, e.cout, e.ovf, e.cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the head of that instance's queue.
    always @(negedge clk) begin
        if (if8.done)  mon(0, if8.sum,  if8.cout,  if8.ovf);
        if (if4.done)  mon(1, if4.sum,  if4.cout,  if4.ovf);
        if (if88.done) mon(2, if88.sum, if88.cout, if88.ovf);
    end

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return if8.ready;
            1: return if4.ready;
            default: return if88.ready;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0: return if8.done;
            1: return if4.done;
            default: return if88.done;
        endcase
    endfunction

    task automatic set_in(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b, input logic ci);
        case (sel)
            0: begin if8.start = st;  if8.a = a;  if8.b = b;  if8.cin = ci;  end
            1: begin if4.start = st;  if4.a = a;  if4.b = b;  if4.cin = ci;  end
            default: begin if88.start = st; if88.a = a; if88.b = b; if88.cin = ci; end
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge with the instance idle; returns #1 after the accepting edge.
    task automatic issue(input int sel, input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int n;
        n = (sel == 0) ? 8 : ((sel == 1) ? 2 : 1);
        chk("ready_before_issue", {31'd0, get_ready(sel)}, 32'd1);
        set_in(sel, 1'b1, a, b, ci);
        tick(1);
        set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + n;
        case (sel)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        chk("ready_low_after_accept", {31'd0, get_ready(sel)}, 32'd0);
    endtask

    task automatic finish_op(input int sel, input int k);
        tick(k);
        chk("done_pulse", {31'd0, get_done(sel)}, 32'd1);
        chk("ready_low_in_done", {31'd0, get_ready(sel)}, 32'd0);
        tick(1);
        chk("ready_after_done", {31'd0, get_ready(sel)}, 32'd1);
        chk("done_one_cycle", {31'd0, get_done(sel)}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_in(2, 1'b0, 8'h00, 8'h00, 1'b0);
        tick(2);
        rst = 1'b0;
        chk("reset_ready", {31'd0, if8.ready}, 32'd1);
        chk("reset_done",  {31'd0, if8.done},  32'd0);
        chk("reset_sum",   {24'd0, if8.sum},   32'h00);
        chk("reset_cout",  {31'd0, if8.cout},  32'd0);
        chk("reset_ovf",   {31'd0, if8.ovf},   32'd0);
        tick(1);

        // Basic add with latency and one-cycle done
        issue(0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        tick(7);
        chk("no_early_done", {31'd0, if8.done}, 32'd0);
        finish_op(0, 1);

        // Carry out, then carry-in only with hold of the previous result
        issue(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        finish_op(0, 8);
        issue(0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        tick(3);
        chk("hold_sum",  {24'd0, if8.sum},  32'h00);
        chk("hold_cout", {31'd0, if8.cout}, 32'd1);
        finish_op(0, 5);

        // Signed overflow cases and an unsigned wrap without overflow
        issue(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OE);
        finish_op(0, 8);
        issue(0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OE);
        finish_op(0, 8);
        issue(0, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0);
        finish_op(0, 8);

        // start during RUN is ignored; ready stays low
        issue(0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            chk("ready_low_in_run", {31'd0, if8.ready}, 32'd0);
            if (i == 2) set_in(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
            if (i == 3) set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
        finish_op(0, 1);
        tick(12);

        // Reset mid-RUN aborts with no done pulse
        issue(0, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        void'(q0.pop_back());
        chk("abort_ready", {31'd0, if8.ready}, 32'd1);
        chk("abort_done",  {31'd0, if8.done},  32'd0);
        chk("abort_sum",   {24'd0, if8.sum},   32'h00);
        chk("abort_cout",  {31'd0, if8.cout},  32'd0);
        tick(10);
        issue(0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        finish_op(0, 8);

        // Wider slices: BPC=4 and BPC=8
        issue(1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        finish_op(1, 2);
        issue(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OE);
        finish_op(1, 2);
        issue(2, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
        finish_op(2, 1);
        issue(2, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, OE);
        finish_op(2, 1);

        tick(4);
        chk("queue0_drained", q0.size(), 32'd0);
        chk("queue1_drained", q1.size(), 32'd0);
        chk("queue2_drained", q2.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
